// File: rtl/serial_byte_loader_pkg.sv
// Shared types and constants for the serial byte loader.
// Holds the FSM state encoding, the default word width and a parity helper.
package serial_byte_loader_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_LOAD   = 2'd3
  } state_e;

  // A frame passes when the XOR over data and parity bit equals the chosen sense.
  function automatic logic parity_ok(input logic xor_all, input logic odd);
    return xor_all == odd;
  endfunction

endpackage

// File: rtl/serial_byte_loader_if.sv
// Serial-stream and register-load bus of the serial byte loader.
// slave is the loader itself; master is whatever feeds the stream and watches the load.
interface serial_byte_loader_if
  import serial_byte_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             ser_valid;
  logic             ser_in;
  logic             abort;
  logic [WIDTH-1:0] data;
  logic             select;
  logic             busy;
  logic             parity_err;
  logic [7:0]       word_cnt;

  modport master (
    output start, ser_valid, ser_in, abort,
    input  data, select, busy, parity_err, word_cnt
  );

  modport slave (
    input  start, ser_valid, ser_in, abort,
    output data, select, busy, parity_err, word_cnt
  );

endinterface

// File: rtl/serial_byte_loader_sipo.sv
// Serial-in/parallel-out shift register with clear and fixed shift direction.
// o_q_next exposes the value the register takes on the coming edge.
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_shift_en,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // LSB-first streams enter at the MSB so the first bit ends up in bit 0.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {i_ser_in, r_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shifted = {r_q[WIDTH-2:0], i_ser_in};
    end
  endgenerate

  always_comb begin
    o_q_next = r_q;
    if (i_clear) begin
      o_q_next = '0;
    end else if (i_shift_en) begin
      o_q_next = w_shifted;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= o_q_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_byte_loader.sv
// Assembles a serial frame (optional parity) into a word and strobes it into
// the downstream load-enable register for one cycle.
module serial_byte_loader
  import serial_byte_loader_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  serial_byte_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_select;
  logic             r_busy;
  logic             r_parity_err;
  logic [7:0]       r_word_cnt;

  logic             w_clear;
  logic             w_shift_en;
  logic             w_perr_set;
  logic             w_perr_clr;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_sipo (
    .i_clk      (i_clk),
    .i_rst_n    (i_reset),
    .i_clear    (w_clear),
    .i_shift_en (w_shift_en),
    .i_ser_in   (bus.ser_in),
    .o_q        (w_q),
    .o_q_next   (w_q_next)
  );

  assign w_last = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_load = (w_state_next == ST_LOAD);

  // abort is tested first everywhere so it beats start and ser_valid.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    w_perr_set   = 1'b0;
    w_perr_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.abort && bus.start) begin
          w_state_next = ST_SHIFT;
          w_clear      = 1'b1;
          w_perr_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          w_state_next = ST_IDLE;
        end else if (bus.ser_valid) begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_state_next = PARITY_EN ? ST_PARITY : ST_LOAD;
          end
        end
      end
      ST_PARITY: begin
        if (bus.abort) begin
          w_state_next = ST_IDLE;
        end else if (bus.ser_valid) begin
          if (parity_ok((^w_q) ^ bus.ser_in, ODD_PARITY)) begin
            w_state_next = ST_LOAD;
          end else begin
            w_state_next = ST_IDLE;
            w_perr_set   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so data and select appear together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_data       <= '0;
      r_select     <= 1'b0;
      r_busy       <= 1'b0;
      r_parity_err <= 1'b0;
      r_word_cnt   <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_select <= w_load;
      r_busy   <= (w_state_next != ST_IDLE);
      if (w_clear) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_data     <= w_q_next;
        r_word_cnt <= r_word_cnt + 8'd1;
      end
      if (w_perr_clr) begin
        r_parity_err <= 1'b0;
      end else if (w_perr_set) begin
        r_parity_err <= 1'b1;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.select     = r_select;
  assign bus.busy       = r_busy;
  assign bus.parity_err = r_parity_err;
  assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Drives four loader variants with one shared stream and compares every output
// each cycle against a frame-level reference model.
module tb_serial_byte_loader;
  import serial_byte_loader_pkg::*;

  localparam int W = 8;
  localparam int N = 4;
  // Variant k: 0 default, 1 MSB-first, 2 no parity, 3 odd parity.
  localparam logic [N-1:0] LSB_CFG = 4'b1101;
  localparam logic [N-1:0] PAR_CFG = 4'b1011;
  localparam logic [N-1:0] ODD_CFG = 4'b1000;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic tbStart = 1'b0;
  logic tbValid = 1'b0;
  logic tbSer = 1'b0;
  logic tbAbort = 1'b0;

  logic [N-1:0][W-1:0] obsData;
  logic [N-1:0][7:0]   obsCnt;
  logic [N-1:0]        obsSelect;
  logic [N-1:0]        obsBusy;
  logic [N-1:0]        obsPerr;

  int checkCount = 0;
  int errorCount = 0;

  int         mPos[N];
  bit         mLoading[N];
  logic [W-1:0] mWord[N];
  logic [W-1:0] mData[N];
  logic       mSelect[N];
  logic       mBusy[N];
  logic       mPerr[N];
  int         mCnt[N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    serial_byte_loader_if #(.WIDTH(W)) bus ();
    serial_byte_loader #(
      .WIDTH      (W),
      .LSB_FIRST  (LSB_CFG[k]),
      .PARITY_EN  (PAR_CFG[k]),
      .ODD_PARITY (ODD_CFG[k])
    ) dut (
      .i_clk   (clk),
      .i_reset (rstN),
      .bus     (bus.slave)
    );
    assign bus.start     = tbStart;
    assign bus.ser_valid = tbValid;
    assign bus.ser_in    = tbSer;
    assign bus.abort     = tbAbort;
    assign obsData[k]    = bus.data;
    assign obsCnt[k]     = bus.word_cnt;
    assign obsSelect[k]  = bus.select;
    assign obsBusy[k]    = bus.busy;
    assign obsPerr[k]    = bus.parity_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModels();
    for (int k = 0; k < N; k++) begin
      mPos[k] = -1; mLoading[k] = 0; mWord[k] = '0; mData[k] = '0;
      mSelect[k] = 0; mBusy[k] = 0; mPerr[k] = 0; mCnt[k] = 0;
    end
  endtask

  // Frame-level view: count accepted bits, place each at its final position,
  // and decide the frame outcome from the popcount once all bits are in.
  task automatic deliver(input int k);
    mData[k] = mWord[k];
    mSelect[k] = 1;
    mLoading[k] = 1;
    mCnt[k] = (mCnt[k] + 1) % 256;
    mPos[k] = -1;
  endtask

  task automatic stepModels(input logic st, input logic sv, input logic si, input logic ab);
    for (int k = 0; k < N; k++) begin
      mSelect[k] = 0;
      if (mLoading[k]) begin
        mLoading[k] = 0;
      end else if (mPos[k] < 0) begin
        if (st && !ab) begin
          mPos[k] = 0; mWord[k] = '0; mPerr[k] = 0;
        end
      end else if (ab) begin
        mPos[k] = -1;
      end else if (sv) begin
        if (mPos[k] < W) begin
          mWord[k][LSB_CFG[k] ? mPos[k] : W - 1 - mPos[k]] = si;
          mPos[k]++;
          if (mPos[k] == W && !PAR_CFG[k]) deliver(k);
        end else if ((($countones(mWord[k]) + int'(si)) % 2) == int'(ODD_CFG[k])) begin
          deliver(k);
        end else begin
          mPos[k] = -1;
          mPerr[k] = 1;
        end
      end
      mBusy[k] = (mPos[k] >= 0) || mLoading[k];
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("k%0d.data", k), 32'(obsData[k]), 32'(mData[k]));
      checkOutput($sformatf("k%0d.select", k), 32'(obsSelect[k]), 32'(mSelect[k]));
      checkOutput($sformatf("k%0d.busy", k), 32'(obsBusy[k]), 32'(mBusy[k]));
      checkOutput($sformatf("k%0d.parity_err", k), 32'(obsPerr[k]), 32'(mPerr[k]));
      checkOutput($sformatf("k%0d.word_cnt", k), 32'(obsCnt[k]), 32'(mCnt[k]));
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sv, input logic si, input logic ab);
    @(negedge clk);
    tbStart = st; tbValid = sv; tbSer = si; tbAbort = ab;
    stepModels(st, sv, si, ab);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // seq[i] is the i-th bit on the wire.
  task automatic sendFrame(input logic [7:0] seq, input int gap, input logic pbit, input bit midStart);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        applyStimulus(midStart && i == 4 && g == 0, 0, 1'($urandom), 0);
      end
      applyStimulus(0, 1, seq[i], 0);
    end
    applyStimulus(0, 1, pbit, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] seq;
    resetModels();
    #2 rstN = 1'b0;
    #1 checkAll();
    @(negedge clk) rstN = 1'b1;

    // Reset in the middle of a frame, between clock edges.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1'(i), 0);
    #2;
    tbStart = 0; tbValid = 0; tbSer = 0; tbAbort = 0;
    rstN = 1'b0;
    resetModels();
    #1;
    checkAll();
    checkOutput("midreset.busy", 32'(obsBusy[0]), 32'd0);
    @(posedge clk);
    #1 checkAll();
    @(negedge clk) rstN = 1'b1;
    sendFrame(8'h5A, 0, 1'b0, 0);
    checkOutput("afterreset.data", 32'(obsData[0]), 32'h5A);

    // Good A5 frame, then the same frame with a bad parity bit.
    sendFrame(8'hA5, 0, 1'b0, 0);
    checkOutput("a5.data", 32'(obsData[0]), 32'hA5);
    checkOutput("a5.msbfirst.data", 32'(obsData[1]), 32'hA5);
    checkOutput("a5.cnt", 32'(obsCnt[0]), 32'd2);
    sendFrame(8'hA5, 0, 1'b1, 0);
    checkOutput("badpar.err", 32'(obsPerr[0]), 32'd1);
    checkOutput("badpar.cnt", 32'(obsCnt[0]), 32'd2);

    // Gapped 3C frame with a stray start in the middle.
    sendFrame(8'h3C, 3, 1'b0, 1);
    checkOutput("gap.data", 32'(obsData[0]), 32'h3C);
    checkOutput("gap.err_cleared", 32'(obsPerr[0]), 32'd0);
    checkOutput("gap.cnt", 32'(obsCnt[0]), 32'd3);

    // Aborts: after five bits, and together with a valid bit.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 0);
    sendFrame(8'hFF, 0, 1'b0, 0);
    checkOutput("abort.data", 32'(obsData[0]), 32'hFF);
    checkOutput("abort.cnt", 32'(obsCnt[0]), 32'd4);

    // 256 good frames bring word_cnt back around to its earlier value.
    for (int f = 0; f < 256; f++) begin
      seq = 8'($urandom);
      sendFrame(seq, 0, ^seq, 0);
    end
    checkOutput("wrap.cnt", 32'(obsCnt[0]), 32'd4);

    // Random traffic, including abort and start landing in LOAD.
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
- Upstream feeder for the 8-bit load-enable register in the datapath.
- Assembles a serial bit stream into a parallel word and checks an optional parity bit.
- Presents the word on data and issues a one-cycle select strobe.
- data/select connect directly to the register's data/select inputs; clk is shared.

Parameters:
WIDTH, 8, assembled word width (register width)
LSB_FIRST, 1, 1 = first serial bit lands in data[0]; 0 = first bit lands in data[WIDTH-1]
PARITY_EN, 1, 1 = a parity bit follows the data bits
ODD_PARITY, 0, 0 = even parity (XOR of data and parity bits = 0); 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a frame; honoured only in IDLE
ser_valid  input  1  ser_in is valid this cycle
ser_in  input  1  serial data bit
abort  input  1  synchronous frame cancel
data  output  WIDTH  last successfully loaded word; drives the register data input
select  output  1  one-cycle load strobe to the register
busy  output  1  high in SHIFT, PARITY and LOAD
parity_err  output  1  sticky; cleared by the next accepted start
word_cnt  output  8  count of successful loads; wraps 255->0

Behaviour:
- Reset (reset=0), immediate and asynchronous: state=IDLE, shift register=0, bit_cnt=0, data=0, select=0, busy=0, parity_err=0, word_cnt=0.
- All outputs are registered.
- IDLE:
  - ser_valid ignored.
  - start=1 -> SHIFT next cycle; bit_cnt<=0; parity_err<=0.
- SHIFT:
  - On each ser_valid=1 cycle, shift in ser_in and increment bit_cnt.
  - LSB_FIRST=1: shift right, new bit enters at MSB. LSB_FIRST=0: shift left, new bit enters at bit 0.
  - ser_valid=0 stalls indefinitely; no timeout.
  - When the WIDTH-th bit is accepted: go to PARITY if PARITY_EN, else LOAD.
- PARITY:
  - On ser_valid=1, compute XOR(shift register, ser_in) and compare against ODD_PARITY.
  - Match -> LOAD.
  - Mismatch -> IDLE, parity_err<=1, data unchanged, no select.
- LOAD (exactly one cycle):
  - data<=shift register and select=1 in the same cycle.
  - word_cnt increments.
  - Next state IDLE.
  - select rises on the clock edge that accepts the last bit (parity bit, or last data bit when PARITY_EN=0); the register captures on the following edge.
- data holds its value until the next LOAD; select is never asserted outside LOAD.
- abort=1:
  - SHIFT/PARITY -> IDLE next cycle; partial word discarded; parity_err and data unchanged.
  - abort has priority over ser_valid in the same cycle.
  - abort in LOAD does not cancel the visible strobe; the state goes to IDLE as normal.
- start outside IDLE is ignored, including the LOAD cycle.
- Back-to-back frames: minimum period is 1 (start) + WIDTH + PARITY_EN + 1 (load) cycles.
- Simultaneous start and abort in IDLE: abort wins; stay in IDLE.
- Reset asserted mid-frame clears everything immediately; a frame restarts only on a new start.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, LOAD=2'd3) and the default WIDTH.
- One natural sub-module, sipo_shift_reg: WIDTH-bit serial-in/parallel-out with shift enable, clear, and direction from LSB_FIRST.
- FSM, bit counter, parity check and word_cnt stay in the top module.

Test Plan:
1. Drive start and 3 bits, then pull reset low between clock edges -> all outputs 0 immediately; after release, state is IDLE and a full frame loads normally.
2. Defaults: start, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), then parity 0 -> select high for exactly one cycle after the parity bit, data=8'hA5, word_cnt=1, parity_err=0, busy low the next cycle.
3. Same frame with parity bit 1 -> no select, parity_err=1, data stays 8'hA5, word_cnt stays 1; the next start clears parity_err.
4. Frame 0x3C with 3-cycle ser_valid gaps between bits; start pulsed mid-frame -> data=8'h3C, a single select, mid-frame start ignored.
5. Abort after 5 bits, then a full frame 0xFF with parity 0 -> exactly one select overall, data=8'hFF; abort in the same cycle as a valid bit -> bit not counted.
6. 256 consecutive good frames -> word_cnt wraps to 0. Repeat case 2 with LSB_FIRST=0 (bits 1,0,1,0,0,1,0,1) -> data=8'hA5. Repeat with PARITY_EN=0 -> select one cycle after the 8th bit.
